wb_regfile: RTL and testbench

Write-back stage and integer register file for the 64-bit RISC-V pipeline. It consumes the registered outputs of the MEM/WB pipeline register, selects the write-back value (ALU result or load data) and commits it to a 32 x 64-bit register file. It serves the two ID-stage read ports and exposes the committed write for the forwarding unit. It also counts register-writing retirements.

---
 rtl/wb_regfile_pkg.sv | 16 +
 rtl/wb_regfile_reg_array.sv | 38 +++
 rtl/wb_regfile.sv | 113 +++++++++++
 tb/tb_wb_regfile.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared RV64 pipeline constants: datapath width, register count and the x0 address.
package rv_pkg;

    localparam int XLEN       = 64;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] regAddr_t;

    localparam regAddr_t ZERO_REG = 5'd0;

    function automatic logic isZeroReg(input regAddr_t addr);
        return (addr == ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_regfile_reg_array.sv
// NREG x XLEN register storage: synchronous active-low clear, one write port, two async read ports.
module reg_array
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN,
    parameter int NREG = rv_pkg::NREG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  regAddr_t        waddr,
    input  logic [XLEN-1:0] wdata,
    input  regAddr_t        raddr1,
    input  regAddr_t        raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs_r [NREG];

    // Storage update: clear has priority over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Asynchronous read of both ports.
    always_comb begin
        rdata1 = regs_r[raddr1];
        rdata2 = regs_r[raddr2];
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and integer register file with retire counter.
// Optional same-cycle write-through to the read ports when WB_BYPASS_EN is defined.
module wb_regfile
    import rv_pkg::*;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int NREG  = rv_pkg::NREG,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_RegWrite,
    input  logic                  wb_MemToReg,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_ReadData,
    input  logic [XLEN-1:0]       wb_ALU_result,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic [XLEN-1:0]       wb_data_out,
    output logic                  wb_we_out,
    output logic [CNT_W-1:0]      retire_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [XLEN-1:0]  wbData_s;
    logic             wbWe_s;
    logic [XLEN-1:0]  arrData1_s;
    logic [XLEN-1:0]  arrData2_s;
    logic [XLEN-1:0]  rs1Data_s;
    logic [XLEN-1:0]  rs2Data_s;
    logic [CNT_W-1:0] retireCount_r;

    // Write-back source select and x0 filter.
    always_comb begin
        if (wb_MemToReg) begin
            wbData_s = wb_ReadData;
        end else begin
            wbData_s = wb_ALU_result;
        end
        wbWe_s = wb_RegWrite && !isZeroReg(wb_rd);
    end

    reg_array #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_reg_array (
        .clk    (clk),
        .reset  (reset),
        .we     (wbWe_s),
        .waddr  (wb_rd),
        .wdata  (wbData_s),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (arrData1_s),
        .rdata2 (arrData2_s)
    );

`ifdef WB_BYPASS_EN
    // Read ports with x0 forced to zero and write-through of the value being committed.
    always_comb begin
        if (isZeroReg(rs1_addr)) begin
            rs1Data_s = {XLEN{1'b0}};
        end else if (wbWe_s && (rs1_addr == wb_rd)) begin
            rs1Data_s = wbData_s;
        end else begin
            rs1Data_s = arrData1_s;
        end
        if (isZeroReg(rs2_addr)) begin
            rs2Data_s = {XLEN{1'b0}};
        end else if (wbWe_s && (rs2_addr == wb_rd)) begin
            rs2Data_s = wbData_s;
        end else begin
            rs2Data_s = arrData2_s;
        end
    end
`else
    // Read ports with x0 forced to zero; a same-cycle write is seen only after the edge.
    always_comb begin
        if (isZeroReg(rs1_addr)) begin
            rs1Data_s = {XLEN{1'b0}};
        end else begin
            rs1Data_s = arrData1_s;
        end
        if (isZeroReg(rs2_addr)) begin
            rs2Data_s = {XLEN{1'b0}};
        end else begin
            rs2Data_s = arrData2_s;
        end
    end
`endif

    // Retire counter: counts effective writes only, wraps freely.
    always_ff @(posedge clk) begin
        if (!reset) begin
            retireCount_r <= {CNT_W{1'b0}};
        end else if (wbWe_s) begin
            retireCount_r <= retireCount_r + CNT_ONE;
        end
    end

    // Output drive.
    always_comb begin
        rs1_data     = rs1Data_s;
        rs2_data     = rs2Data_s;
        wb_data_out  = wbData_s;
        wb_we_out    = wbWe_s;
        retire_count = retireCount_r;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver queues expected values per cycle, monitor compares on negedge.
module tb_wb_regfile;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    localparam int K_RS1 = 0;
    localparam int K_RS2 = 1;
    localparam int K_CNT = 2;
    localparam int K_WE  = 3;
    localparam int K_WBD = 4;

    logic             clk;
    logic             reset;
    logic             wb_RegWrite;
    logic             wb_MemToReg;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_ReadData;
    logic [XLEN-1:0]  wb_ALU_result;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  wb_data_out;
    logic             wb_we_out;
    logic [CNT_W-1:0] retire_count;

    typedef struct {
        int          cyc;
        int          kind;
        logic [63:0] exp;
    } chk_t;

    chk_t q[$];
    int   cyc;
    int   checks;
    int   errors;

    wb_regfile #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_RegWrite   (wb_RegWrite),
        .wb_MemToReg   (wb_MemToReg),
        .wb_rd         (wb_rd),
        .wb_ReadData   (wb_ReadData),
        .wb_ALU_result (wb_ALU_result),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .wb_data_out   (wb_data_out),
        .wb_we_out     (wb_we_out),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kindName(input int k);
        case (k)
            K_RS1:   return "rs1_data";
            K_RS2:   return "rs2_data";
            K_CNT:   return "retire_count";
            K_WE:    return "wb_we_out";
            K_WBD:   return "wb_data_out";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: pops every entry queued for the current cycle and compares it.
    always @(negedge clk) begin
        chk_t        c;
        logic [63:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            c = q.pop_front();
            checks++;
            case (c.kind)
                K_RS1:   act = rs1_data;
                K_RS2:   act = rs2_data;
                K_CNT:   act = {60'd0, retire_count};
                K_WE:    act = {63'd0, wb_we_out};
                K_WBD:   act = wb_data_out;
                default: act = 64'hX;
            endcase
            if (c.cyc != cyc) begin
                errors++;
                $display("FAIL %s stale entry for cycle %0d seen at cycle %0d", kindName(c.kind), c.cyc, cyc);
            end else if (act !== c.exp) begin
                errors++;
                $display("FAIL %s cycle %0d actual %h required %h", kindName(c.kind), cyc, act, c.exp);
            end
        end
    end

    task automatic pushExp(input int kind, input logic [63:0] e);
        q.push_back('{cyc, kind, e});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setWrite(input logic we, input logic m2r, input logic [4:0] rd,
                            input logic [63:0] rdata, input logic [63:0] alu);
        wb_RegWrite   = we;
        wb_MemToReg   = m2r;
        wb_rd         = rd;
        wb_ReadData   = rdata;
        wb_ALU_result = alu;
    endtask

    initial begin
        int wait_cycles;
        checks = 0;
        errors = 0;
        reset = 1'b0;
        setWrite(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;

        // Reset for two edges, then sweep every address on both ports.
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) step();
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            pushExp(K_RS1, 64'd0);
            pushExp(K_RS2, 64'd0);
            if (i == 0) pushExp(K_CNT, 64'd0);
        end

        // ALU-result write to x5.
        step();
        setWrite(1'b1, 1'b0, 5'd5, 64'h1111, 64'h0000_0000_DEAD_BEEF);
        pushExp(K_WBD, 64'h0000_0000_DEAD_BEEF);
        pushExp(K_WE, 64'd1);
        step();
        setWrite(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        rs1_addr = 5'd5;
        pushExp(K_RS1, 64'h0000_0000_DEAD_BEEF);
        pushExp(K_CNT, 64'd1);

        // Write to x0 is discarded and not counted.
        step();
        setWrite(1'b1, 1'b0, 5'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        rs1_addr = 5'd0;
        pushExp(K_WE, 64'd0);
        pushExp(K_WBD, 64'hFFFF_FFFF_FFFF_FFFF);
        pushExp(K_RS1, 64'd0);
        step();
        setWrite(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        pushExp(K_RS1, 64'd0);
        pushExp(K_CNT, 64'd1);

        // Back-to-back writes to x7; second one read in the same cycle.
        step();
        setWrite(1'b1, 1'b0, 5'd7, 64'd0, 64'h55);
        step();
        setWrite(1'b1, 1'b0, 5'd7, 64'd0, 64'h1234);
        rs1_addr = 5'd5;
        rs2_addr = 5'd7;
`ifdef WB_BYPASS_EN
        pushExp(K_RS2, 64'h1234);
`else
        pushExp(K_RS2, 64'h55);
`endif
        pushExp(K_RS1, 64'h0000_0000_DEAD_BEEF);
        pushExp(K_CNT, 64'd2);
        step();
        setWrite(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        pushExp(K_RS2, 64'h1234);
        pushExp(K_CNT, 64'd3);

        // Load-data write to x9.
        step();
        setWrite(1'b1, 1'b1, 5'd9, 64'hA5A5, 64'h1);
        pushExp(K_WBD, 64'hA5A5);
        step();
        setWrite(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        rs1_addr = 5'd9;
        pushExp(K_RS1, 64'hA5A5);
        pushExp(K_CNT, 64'd4);

        // Reset concurrent with a write to x9: reset wins.
        step();
        reset = 1'b0;
        setWrite(1'b1, 1'b0, 5'd9, 64'd0, 64'h77);

        // First cycle out of reset also starts the wrap sequence (writes x1..x15).
        step();
        reset = 1'b1;
        setWrite(1'b1, 1'b0, 5'd1, 64'd0, 64'h100);
        rs1_addr = 5'd9;
        rs2_addr = 5'd7;
        pushExp(K_RS1, 64'd0);
        pushExp(K_RS2, 64'd0);
        pushExp(K_CNT, 64'd0);
        for (int i = 1; i < 15; i++) begin
            step();
            setWrite(1'b1, 1'b0, 5'(i + 1), 64'd0, 64'h100 + 64'(i));
        end
        step();
        setWrite(1'b1, 1'b0, 5'd20, 64'd0, 64'hABC);
        rs1_addr = 5'd3;
        rs2_addr = 5'd15;
        pushExp(K_CNT, 64'd15);
        pushExp(K_RS1, 64'h102);
        pushExp(K_RS2, 64'h10E);
        step();
        setWrite(1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        rs1_addr = 5'd20;
        pushExp(K_CNT, 64'd0);
        pushExp(K_RS1, 64'hABC);

        // Drain the scoreboard with a bounded wait.
        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            step();
            wait_cycles++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain %0d entries left, required 0", q.size());
        end
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
